gerenciador_rolhas: RTL and testbench
=====================================

GERENCIADOR_ROLHAS -- requirements
Module: gerenciador_rolhas

Interface
REQ-001 Parameter CAPACIDADE, default 15, magazine capacity in corks (1..31).
REQ-002 Parameter LOTE, default 5, corks added per refill.
REQ-003 Parameter NIVEL_MIN, default 3, auto-refill threshold: refill when estoque < NIVEL_MIN.
REQ-004 Parameter TEMPO_ENTREGA, default 10000000, cycles per cork dispense (0.2 s at 50 MHz).
REQ-005 Parameter TEMPO_RECARGA, default 50000000, cycles per refill operation (1.0 s).
REQ-006 Port clk  input  1  50 MHz clock; the block has one clock; all state changes on its rising edge.
REQ-007 Port reset  input  1  reset, asynchronous and active-low (0 = reset).
REQ-008 Port pedido_rolha  input  1  level from the sealing FSM requesting one cork.
REQ-009 Port pulso_recarga  input  1  one-cycle debounced operator refill pulse (KEY1).
REQ-010 Port habilitar_auto  input  1  switch enabling automatic refill.
REQ-011 Port rolha_entregue  output  1  one-cycle pulse: one cork delivered.
REQ-012 Port alarme_rolha  output  1  high while estoque == 0; feeds the master sequencer.
REQ-013 Port recarregando  output  1  high during a refill operation (LED).
REQ-014 Port recarga_ignorada  output  1  one-cycle pulse: refill rejected because the magazine is full.
REQ-015 Port estoque  output  5  current cork count, unsigned.

Function
REQ-016 The FSM SHALL have states OCIOSO, ENTREGANDO, CONFIRMA, AGUARDA_LIBERA and RECARGA.
REQ-017 A pulso_recarga SHALL set a pending-refill flag in any state; the flag clears when RECARGA is entered or the refill is rejected.
REQ-018 OCIOSO: need_refill = pending flag, or (habilitar_auto and estoque < NIVEL_MIN).
REQ-019 OCIOSO: if estoque == 0 and need_refill, go to RECARGA.
REQ-020 OCIOSO: otherwise, if pedido_rolha and estoque > 0, go to ENTREGANDO.
REQ-021 OCIOSO: otherwise, if need_refill, go to RECARGA; dispensing has priority over refill while stock > 0.
REQ-022 Entering RECARGA with estoque == CAPACIDADE SHALL instead pulse recarga_ignorada for one cycle, clear the flag and stay in OCIOSO; auto refill never rejects, since NIVEL_MIN <= CAPACIDADE.
REQ-023 ENTREGANDO SHALL last exactly TEMPO_ENTREGA cycles, then go to CONFIRMA; the timer clears on every state entry.
REQ-024 CONFIRMA SHALL last one cycle, assert rolha_entregue and decrement estoque by 1, then go to AGUARDA_LIBERA.
REQ-025 AGUARDA_LIBERA SHALL return to OCIOSO only when pedido_rolha == 0, so one request level yields exactly one cork.
REQ-026 If pedido_rolha drops during ENTREGANDO, the dispense SHALL still complete: one pulse, one decrement.
REQ-027 RECARGA SHALL assert recarregando, last exactly TEMPO_RECARGA cycles, then set estoque = min(estoque + LOTE, CAPACIDADE) and return to OCIOSO.
REQ-028 The addition in REQ-027 SHALL use at least 6 bits, so saturation never wraps.
REQ-029 A pedido_rolha arriving during RECARGA SHALL wait and is not lost; a pulso_recarga arriving during RECARGA causes a further refill afterwards, per REQ-021/022.
REQ-030 estoque SHALL never underflow; with estoque == 0, pedido_rolha is not granted and alarme_rolha stays 1.
REQ-031 All outputs SHALL be registered or decoded from state/count only (Moore); no input-to-output combinational path.

Reset
REQ-032 reset == 0 SHALL immediately force OCIOSO, clear timers and the pending flag, and set estoque = CAPACIDADE.
REQ-033 During reset, outputs SHALL be rolha_entregue = recarregando = recarga_ignorada = alarme_rolha = 0.
REQ-034 A reset during ENTREGANDO or RECARGA SHALL abort the operation with no pulse and no count change beyond REQ-032.

Verification (CAPACIDADE=6, LOTE=4, NIVEL_MIN=2, TEMPO_ENTREGA=3, TEMPO_RECARGA=5, habilitar_auto=0 unless stated)
REQ-035 Reset release, hold pedido_rolha high for 20 cycles -> exactly one rolha_entregue pulse, TEMPO_ENTREGA+1 cycles after ENTREGANDO entry; estoque 6->5.
REQ-036 Six request/release handshakes -> estoque reaches 0 and alarme_rolha = 1; a seventh request gets no pulse.
REQ-037 At estoque=0, pulso_recarga -> recarregando high for 5 cycles; estoque = 4; alarme_rolha = 0.
REQ-038 At estoque=5, pulso_recarga -> estoque = 6 (saturated); then a further pulse -> recarga_ignorada one-cycle pulse, estoque stays 6.
REQ-039 habilitar_auto=1, estoque=2, one dispense -> estoque 1, then automatic RECARGA -> estoque = 5; a pedido asserted mid-refill is served afterwards.
REQ-040 reset pulled low mid-ENTREGANDO at estoque=3 -> no rolha_entregue pulse; estoque = 6 after release.

Source files
------------

// File: rtl/gerenciador_rolhas.sv
// Cork magazine manager: dispenses one cork per request handshake and refills
// the magazine on operator pulse or automatically when stock runs low.
module gerenciador_rolhas #(
    parameter int CAPACIDADE    = 15,
    parameter int LOTE          = 5,
    parameter int NIVEL_MIN     = 3,
    parameter int TEMPO_ENTREGA = 10000000,
    parameter int TEMPO_RECARGA = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pedido_rolha,
    input  logic       pulso_recarga,
    input  logic       habilitar_auto,
    output logic       rolha_entregue,
    output logic       alarme_rolha,
    output logic       recarregando,
    output logic       recarga_ignorada,
    output logic [4:0] estoque
);

    typedef enum logic [2:0] {
        OCIOSO,
        ENTREGANDO,
        CONFIRMA,
        AGUARDA_LIBERA,
        RECARGA
    } estado_t;

    localparam logic [4:0]  CAP5        = 5'(CAPACIDADE);
    localparam logic [5:0]  CAP6        = 6'(CAPACIDADE);
    localparam logic [5:0]  NIVEL6      = 6'(NIVEL_MIN);
    localparam logic [5:0]  LOTE6       = 6'(LOTE);
    localparam logic [31:0] FIM_ENTREGA = 32'(TEMPO_ENTREGA - 1);
    localparam logic [31:0] FIM_RECARGA = 32'(TEMPO_RECARGA - 1);

    estado_t     state_reg, state_next;
    logic [31:0] timer_reg, timer_next;
    logic [4:0]  estoque_reg, estoque_next;
    logic        pendente_reg, pendente_next;
    logic        ignorada_reg, ignorada_next;
    logic        precisa_recarga;
    logic [5:0]  soma;

    // Six-bit sum so that stock + batch can exceed the capacity without wrapping.
    assign soma = {1'b0, estoque_reg} + LOTE6;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= OCIOSO;
            timer_reg    <= '0;
            estoque_reg  <= CAP5;
            pendente_reg <= 1'b0;
            ignorada_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            estoque_reg  <= estoque_next;
            pendente_reg <= pendente_next;
            ignorada_reg <= ignorada_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        timer_next      = '0;
        estoque_next    = estoque_reg;
        pendente_next   = pendente_reg | pulso_recarga;
        ignorada_next   = 1'b0;
        precisa_recarga = pendente_reg |
                          (habilitar_auto & ({1'b0, estoque_reg} < NIVEL6));

        case (state_reg)
            OCIOSO: begin
                if (estoque_reg == 5'd0 && precisa_recarga) begin
                    state_next    = RECARGA;
                    pendente_next = pulso_recarga;
                end else if (pedido_rolha && estoque_reg != 5'd0) begin
                    state_next = ENTREGANDO;
                end else if (precisa_recarga) begin
                    // A pulse landing in the same cycle survives the clear.
                    pendente_next = pulso_recarga;
                    if (estoque_reg == CAP5) begin
                        ignorada_next = 1'b1;
                    end else begin
                        state_next = RECARGA;
                    end
                end
            end
            ENTREGANDO: begin
                if (timer_reg == FIM_ENTREGA) begin
                    state_next = CONFIRMA;
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
            end
            CONFIRMA: begin
                if (estoque_reg != 5'd0) begin
                    estoque_next = estoque_reg - 5'd1;
                end
                state_next = AGUARDA_LIBERA;
            end
            AGUARDA_LIBERA: begin
                if (!pedido_rolha) begin
                    state_next = OCIOSO;
                end
            end
            RECARGA: begin
                if (timer_reg == FIM_RECARGA) begin
                    estoque_next = (soma > CAP6) ? CAP5 : soma[4:0];
                    state_next   = OCIOSO;
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
            end
            default: state_next = OCIOSO;
        endcase
    end

    assign rolha_entregue   = (state_reg == CONFIRMA);
    assign recarregando     = (state_reg == RECARGA);
    assign alarme_rolha     = (estoque_reg == 5'd0);
    assign recarga_ignorada = ignorada_reg;
    assign estoque          = estoque_reg;

endmodule

// File: tb/tb_gerenciador_rolhas.sv
// Directed bench for gerenciador_rolhas with short timings (cap 6, batch 4,
// threshold 2, dispense 3 cycles, refill 5 cycles).
module tb_gerenciador_rolhas;

    localparam int CAP = 6;
    localparam int LT  = 4;
    localparam int NM  = 2;
    localparam int TE  = 3;
    localparam int TR  = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pedido_rolha = 1'b0;
    logic       pulso_recarga = 1'b0;
    logic       habilitar_auto = 1'b0;
    logic       rolha_entregue;
    logic       alarme_rolha;
    logic       recarregando;
    logic       recarga_ignorada;
    logic [4:0] estoque;

    int checks = 0;
    int failures = 0;

    gerenciador_rolhas #(
        .CAPACIDADE(CAP), .LOTE(LT), .NIVEL_MIN(NM),
        .TEMPO_ENTREGA(TE), .TEMPO_RECARGA(TR)
    ) dut (
        .clk(clk), .reset(reset),
        .pedido_rolha(pedido_rolha), .pulso_recarga(pulso_recarga),
        .habilitar_auto(habilitar_auto),
        .rolha_entregue(rolha_entregue), .alarme_rolha(alarme_rolha),
        .recarregando(recarregando), .recarga_ignorada(recarga_ignorada),
        .estoque(estoque)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request/release handshake: request held 8 cycles, then released.
    task automatic handshake(output int pulses);
        pulses = 0;
        pedido_rolha = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rolha_entregue) pulses++;
        end
        pedido_rolha = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (rolha_entregue) pulses++;
        end
    endtask

    // One operator refill pulse, then observe for 12 cycles.
    task automatic refill_pulse(output int rec_cycles, output int ign_cycles);
        rec_cycles = 0;
        ign_cycles = 0;
        pulso_recarga = 1'b1;
        step();
        pulso_recarga = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (recarregando) rec_cycles++;
            if (recarga_ignorada) ign_cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        checks++;
        if (estoque !== 5'd6 || alarme_rolha !== 1'b0 || rolha_entregue !== 1'b0 ||
            recarregando !== 1'b0 || recarga_ignorada !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: estoque=%0d alarme=%b entregue=%b rec=%b ign=%b, required 6 0 0 0 0",
                     estoque, alarme_rolha, rolha_entregue, recarregando, recarga_ignorada);
        end
        reset = 1'b1;
        step();
        $display("reset: estoque=%0d", estoque);
    endtask

    task automatic test_single_dispense();
        int pulses = 0;
        int first = -1;
        pedido_rolha = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (rolha_entregue) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL single_pulses: got %0d, required 1", pulses);
        end
        checks++;
        if (first != TE + 1) begin
            failures++;
            $display("FAIL single_latency: pulse at cycle %0d, required %0d", first, TE + 1);
        end
        checks++;
        if (estoque !== 5'd5) begin
            failures++;
            $display("FAIL single_estoque: got %0d, required 5", estoque);
        end
        pedido_rolha = 1'b0;
        step(); step();
        $display("single dispense: pulses=%0d at=%0d estoque=%0d", pulses, first, estoque);
    endtask

    task automatic test_drain();
        int p;
        for (int k = 0; k < 5; k++) begin
            handshake(p);
            checks++;
            if (p != 1 || estoque !== 5'(4 - k)) begin
                failures++;
                $display("FAIL drain_%0d: pulses=%0d estoque=%0d, required 1 and %0d", k, p, estoque, 4 - k);
            end
            $display("drain handshake %0d: pulses=%0d estoque=%0d", k, p, estoque);
        end
        checks++;
        if (alarme_rolha !== 1'b1) begin
            failures++;
            $display("FAIL drain_alarme: got %b, required 1", alarme_rolha);
        end
        handshake(p);
        checks++;
        if (p != 0 || estoque !== 5'd0 || alarme_rolha !== 1'b1) begin
            failures++;
            $display("FAIL empty_request: pulses=%0d estoque=%0d alarme=%b, required 0 0 1", p, estoque, alarme_rolha);
        end
        $display("seventh request at empty: pulses=%0d estoque=%0d", p, estoque);
    endtask

    task automatic test_manual_refill();
        int rc, ic;
        refill_pulse(rc, ic);
        checks++;
        if (rc != TR || estoque !== 5'd4 || alarme_rolha !== 1'b0) begin
            failures++;
            $display("FAIL refill_empty: rec=%0d estoque=%0d alarme=%b, required %0d 4 0", rc, estoque, alarme_rolha, TR);
        end
        $display("refill from empty: rec=%0d estoque=%0d", rc, estoque);
    endtask

    task automatic test_saturate();
        int rc, ic, p;
        refill_pulse(rc, ic);
        checks++;
        if (estoque !== 5'd6 || rc != TR) begin
            failures++;
            $display("FAIL refill_4: estoque=%0d rec=%0d, required 6 %0d", estoque, rc, TR);
        end
        handshake(p);
        refill_pulse(rc, ic);
        checks++;
        if (estoque !== 5'd6 || rc != TR || ic != 0) begin
            failures++;
            $display("FAIL refill_5: estoque=%0d rec=%0d ign=%0d, required 6 %0d 0", estoque, rc, ic, TR);
        end
        $display("refill at 5: estoque=%0d rec=%0d", estoque, rc);
        refill_pulse(rc, ic);
        checks++;
        if (ic != 1 || rc != 0 || estoque !== 5'd6) begin
            failures++;
            $display("FAIL refill_full: ign=%0d rec=%0d estoque=%0d, required 1 0 6", ic, rc, estoque);
        end
        $display("refill when full: ign=%0d rec=%0d estoque=%0d", ic, rc, estoque);
    endtask

    task automatic test_auto_refill();
        int p;
        int rc = 0;
        int pulses = 0;
        int est_refill = -1;
        bit seen = 1'b0;
        for (int k = 0; k < 4; k++) handshake(p);
        checks++;
        if (estoque !== 5'd2) begin
            failures++;
            $display("FAIL auto_setup: estoque=%0d, required 2", estoque);
        end
        habilitar_auto = 1'b1;
        pedido_rolha = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (rolha_entregue) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL auto_dispense: no pulse within 10 cycles, required 1");
        end
        step();
        checks++;
        if (estoque !== 5'd1) begin
            failures++;
            $display("FAIL auto_after_dispense: estoque=%0d, required 1", estoque);
        end
        pedido_rolha = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 3) pedido_rolha = 1'b1;
            if (recarregando) rc++;
            if (rolha_entregue) pulses++;
            if (rc > 0 && !recarregando && est_refill < 0) est_refill = int'(estoque);
        end
        checks++;
        if (rc != TR || est_refill != 5) begin
            failures++;
            $display("FAIL auto_refill: rec=%0d estoque_after=%0d, required %0d 5", rc, est_refill, TR);
        end
        checks++;
        if (pulses != 1 || estoque !== 5'd4) begin
            failures++;
            $display("FAIL auto_pending_request: pulses=%0d estoque=%0d, required 1 4", pulses, estoque);
        end
        $display("auto refill: rec=%0d after=%0d pulses=%0d estoque=%0d", rc, est_refill, pulses, estoque);
        pedido_rolha = 1'b0;
        habilitar_auto = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_mid_dispense();
        int p;
        int pulses = 0;
        handshake(p);
        checks++;
        if (estoque !== 5'd3) begin
            failures++;
            $display("FAIL abort_setup: estoque=%0d, required 3", estoque);
        end
        pedido_rolha = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        checks++;
        if (estoque !== 5'd6 || rolha_entregue !== 1'b0) begin
            failures++;
            $display("FAIL abort_async: estoque=%0d entregue=%b, required 6 0", estoque, rolha_entregue);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (rolha_entregue) pulses++;
        end
        pedido_rolha = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rolha_entregue) pulses++;
        end
        checks++;
        if (pulses != 0 || estoque !== 5'd6) begin
            failures++;
            $display("FAIL abort_result: pulses=%0d estoque=%0d, required 0 6", pulses, estoque);
        end
        $display("reset mid-dispense: pulses=%0d estoque=%0d", pulses, estoque);
    endtask

    initial begin
        test_reset();
        test_single_dispense();
        test_drain();
        test_manual_refill();
        test_saturate();
        test_auto_refill();
        test_reset_mid_dispense();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
